// File: rtl/dlk_pcm_sequencer.sv
// AGC digital downlink sequencer: DKSTRT/DKBSNC/DKEND strobe train generation
// and DKDATA word-pair capture onto a valid/ready port.
module dlk_pcm_sequencer #(
  parameter int unsigned DIV_LEN     = 21,
  parameter int unsigned PULSE_LEN   = 4,
  parameter int unsigned NBITS       = 40,
  parameter int unsigned FRAME_SLOTS = 1024
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             CLK,
  input  logic             DKDATA,
  input  logic             enable,
  output logic             DKSTRT,
  output logic             DKBSNC,
  output logic             DKEND,
  output logic [NBITS-1:0] dl_word,
  output logic             dl_valid,
  input  logic             dl_ready,
  output logic             dl_overrun,
  output logic [15:0]      frame_cnt
);
  localparam int unsigned DW = (DIV_LEN > 1) ? $clog2(DIV_LEN) : 1;
  localparam int unsigned SW = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_END, S_GAP} state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_div, w_div_nxt;
  logic [SW-1:0]   r_slot, w_slot_nxt, w_slot_inc;
  logic            r_clk_s1, r_clk_s2, r_clk_s3;
  logic            r_dk_s1, r_dk_s2;
  logic            w_ce, w_sample;
  logic            w_strt_nxt, w_bsnc_nxt, w_end_nxt;
  logic            r_strt, r_bsnc, r_end;
  logic [NBITS-1:0] r_shift, r_word;
  logic            r_valid, r_overrun;
  logic [15:0]     r_cnt;

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_s3 <= 1'b0;
      r_dk_s1  <= 1'b0;
      r_dk_s2  <= 1'b0;
    end else begin
      r_clk_s1 <= CLK;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dk_s1  <= DKDATA;
      r_dk_s2  <= r_dk_s1;
    end
  end

  assign w_ce       = r_clk_s2 & ~r_clk_s3;
  assign w_slot_inc = r_slot + SW'(1);

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_slot_nxt  = r_slot;
    if (w_ce) begin
      if (r_state == S_IDLE) begin
        if (enable) begin
          w_state_nxt = S_START;
          w_div_nxt   = '0;
          w_slot_nxt  = '0;
        end
      end else if (r_div == DW'(DIV_LEN - 1)) begin
        w_div_nxt = '0;
        if (r_slot == SW'(FRAME_SLOTS - 1)) begin
          w_slot_nxt  = '0;
          w_state_nxt = enable ? S_START : S_IDLE;
        end else begin
          w_slot_nxt = w_slot_inc;
          if (w_slot_inc == SW'(1))              w_state_nxt = S_BITS;
          else if (w_slot_inc == SW'(NBITS + 1)) w_state_nxt = S_END;
          else if (w_slot_inc == SW'(NBITS + 2)) w_state_nxt = S_GAP;
        end
      end else begin
        w_div_nxt = r_div + DW'(1);
      end
    end
  end

  // Strobes are derived from the next state so the registered outputs line up with the slot/div they belong to.
  always_comb begin
    w_strt_nxt = 1'b0;
    w_bsnc_nxt = 1'b0;
    w_end_nxt  = 1'b0;
    if (w_div_nxt < DW'(PULSE_LEN)) begin
      w_strt_nxt = (w_state_nxt == S_START);
      w_bsnc_nxt = (w_state_nxt == S_BITS);
      w_end_nxt  = (w_state_nxt == S_END);
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_strt <= 1'b0;
      r_bsnc <= 1'b0;
      r_end  <= 1'b0;
    end else begin
      r_strt <= w_strt_nxt;
      r_bsnc <= w_bsnc_nxt;
      r_end  <= w_end_nxt;
    end
  end

  assign w_sample = w_ce && (r_state != S_IDLE) && (r_div == DW'(PULSE_LEN - 1));

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_shift   <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_sample && r_state == S_START) r_shift <= '0;
      else if (w_sample && r_state == S_BITS) r_shift <= {r_shift[NBITS-2:0], r_dk_s2};
      if (w_sample && r_state == S_END) begin
        if (!r_valid || dl_ready) begin
          r_word  <= r_shift;
          r_valid <= 1'b1;
          r_cnt   <= r_cnt + 16'd1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && dl_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign DKSTRT     = r_strt;
  assign DKBSNC     = r_bsnc;
  assign DKEND      = r_end;
  assign dl_word    = r_word;
  assign dl_valid   = r_valid;
  assign dl_overrun = r_overrun;
  assign frame_cnt  = r_cnt;
endmodule

// File: tb/tb_dlk_pcm_sequencer.sv
// Directed bench for dlk_pcm_sequencer with a shortened frame geometry;
// strobe timing is checked edge-by-edge against a slot/div model.
module tb_dlk_pcm_sequencer;
  localparam int DIV = 6;
  localparam int PUL = 2;
  localparam int NB  = 40;
  localparam int FS  = 44;
  localparam int LAST_N = FS * DIV - 1;
  localparam int END_SAMPLE_N = (NB + 1) * DIV + PUL;

  logic SIM_CLK, SIM_RST, CLK, DKDATA, enable, dl_ready;
  logic DKSTRT, DKBSNC, DKEND, dl_valid, dl_overrun;
  logic [NB-1:0] dl_word;
  logic [15:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  int strobe_bad, onehot_bad, valid_cyc, idle_bad;
  int rise_s, rise_b, rise_e;
  logic p_s = 1'b0, p_b = 1'b0, p_e = 1'b0;
  logic [79:0] snap;

  dlk_pcm_sequencer #(
    .DIV_LEN(DIV), .PULSE_LEN(PUL), .NBITS(NB), .FRAME_SLOTS(FS)
  ) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .CLK(CLK), .DKDATA(DKDATA),
    .enable(enable), .DKSTRT(DKSTRT), .DKBSNC(DKBSNC), .DKEND(DKEND),
    .dl_word(dl_word), .dl_valid(dl_valid), .dl_ready(dl_ready),
    .dl_overrun(dl_overrun), .frame_cnt(frame_cnt)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    strobe_bad = 0; onehot_bad = 0; valid_cyc = 0; idle_bad = 0;
    rise_s = 0; rise_b = 0; rise_e = 0;
  endtask

  task automatic mon();
    if (dl_valid) valid_cyc++;
    if (int'(DKSTRT) + int'(DKBSNC) + int'(DKEND) > 1) onehot_bad++;
  endtask

  // One AGC CLK period, entered and left on a SIM_CLK falling edge; rp pulses
  // dl_ready around the cycle where the CLK edge takes effect.
  task automatic clk_edge(input bit rp);
    CLK = 1'b1;
    @(negedge SIM_CLK); mon();
    @(negedge SIM_CLK); if (rp) dl_ready = 1'b1; mon();
    @(negedge SIM_CLK); if (rp) dl_ready = 1'b0; mon();
    CLK = 1'b0;
    repeat (3) begin @(negedge SIM_CLK); mon(); end
  endtask

  task automatic track();
    if (DKSTRT && !p_s) rise_s++;
    if (DKBSNC && !p_b) rise_b++;
    if (DKEND  && !p_e) rise_e++;
    p_s = DKSTRT; p_b = DKBSNC; p_e = DKEND;
  endtask

  task automatic run(input logic [NB-1:0] w, input int n0, input int n1, input int rp_n);
    for (int n = n0; n <= n1; n++) begin
      int slot, dv;
      logic es, eb, ee;
      slot = n / DIV;
      dv   = n % DIV;
      DKDATA = (slot >= 1 && slot <= NB) ? w[NB-slot] : 1'b0;
      clk_edge(n == rp_n);
      es = (slot == 0) && (dv < PUL);
      eb = (slot >= 1) && (slot <= NB) && (dv < PUL);
      ee = (slot == NB + 1) && (dv < PUL);
      if ({DKSTRT, DKBSNC, DKEND} !== {es, eb, ee}) strobe_bad++;
      track();
    end
  endtask

  task automatic idle_edges(input int k);
    for (int i = 0; i < k; i++) begin
      clk_edge(1'b0);
      if (DKSTRT || DKBSNC || DKEND) idle_bad++;
      track();
    end
  endtask

  task automatic check_frame_strobes(input string tag);
    check({tag, "_strobe_timing"}, strobe_bad, 0);
    check({tag, "_onehot"}, onehot_bad, 0);
    check({tag, "_dkstrt_count"}, rise_s, 1);
    check({tag, "_dkbsnc_count"}, rise_b, NB);
    check({tag, "_dkend_count"}, rise_e, 1);
  endtask

  initial begin
    SIM_RST = 1'b1; CLK = 1'b0; DKDATA = 1'b0; enable = 1'b0; dl_ready = 1'b0;
    clr();
    repeat (4) @(negedge SIM_CLK);
    check("rst_strobes", {DKSTRT, DKBSNC, DKEND}, 0);
    check("rst_valid", dl_valid, 0);
    check("rst_overrun", dl_overrun, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_word", dl_word, 0);
    SIM_RST = 1'b0;
    @(negedge SIM_CLK);
    idle_edges(3);
    check("idle_no_strobes", idle_bad, 0);

    // Single frame, known pattern, consumer always ready
    enable = 1'b1; dl_ready = 1'b1; clr();
    run(40'hA5F0C31E77, 0, LAST_N, -1);
    check_frame_strobes("t2");
    check("t2_word", dl_word, 40'hA5F0C31E77);
    check("t2_cnt", frame_cnt, 1);
    check("t2_valid_cycles", valid_cyc, 1);

    clr();
    run(40'h123456789A, 0, LAST_N, -1);
    check_frame_strobes("t1");
    check("t1_word", dl_word, 40'h123456789A);
    check("t1_cnt", frame_cnt, 2);

    // Back-pressure: second word dropped, first held
    dl_ready = 1'b0; clr();
    run(40'h0F0F0F0F0F, 0, LAST_N, -1);
    check("t3_valid1", dl_valid, 1);
    check("t3_word1", dl_word, 40'h0F0F0F0F0F);
    check("t3_cnt1", frame_cnt, 3);
    run(40'h3C3C3C3C3C, 0, LAST_N, -1);
    check("t3_overrun", dl_overrun, 1);
    check("t3_word_held", dl_word, 40'h0F0F0F0F0F);
    check("t3_cnt_held", frame_cnt, 3);
    check("t3_valid_held", dl_valid, 1);
    dl_ready = 1'b1;
    @(negedge SIM_CLK);
    dl_ready = 1'b0;
    check("t3_valid_fall", dl_valid, 0);
    check("t3_word_after", dl_word, 40'h0F0F0F0F0F);
    check("t3_overrun_sticky", dl_overrun, 1);

    SIM_RST = 1'b1;
    repeat (2) @(negedge SIM_CLK);
    check("rst2_overrun", dl_overrun, 0);
    check("rst2_cnt", frame_cnt, 0);
    SIM_RST = 1'b0;
    @(negedge SIM_CLK);

    // Handshake coinciding with the END-sample load
    run(40'hC0FFEE1234, 0, LAST_N, -1);
    check("t4_first_valid", dl_valid, 1);
    check("t4_first_word", dl_word, 40'hC0FFEE1234);
    run(40'h5A5A00FF11, 0, LAST_N, END_SAMPLE_N);
    check("t4_word", dl_word, 40'h5A5A00FF11);
    check("t4_valid", dl_valid, 1);
    check("t4_overrun", dl_overrun, 0);
    check("t4_cnt", frame_cnt, 2);
    dl_ready = 1'b1;
    @(negedge SIM_CLK);
    check("t4_drain", dl_valid, 0);

    // Reset mid-frame at slot 20
    clr();
    run(40'h8000000001, 0, 20 * DIV, -1);
    check("t5_pre_bsnc", DKBSNC, 1);
    SIM_RST = 1'b1;
    @(negedge SIM_CLK);
    check("t5_strobes_drop", {DKSTRT, DKBSNC, DKEND}, 0);
    check("t5_cnt_clear", frame_cnt, 0);
    SIM_RST = 1'b0;
    @(negedge SIM_CLK);
    check("t5_no_partial_valid", valid_cyc, 0);
    clr(); p_s = 1'b0; p_b = 1'b0; p_e = 1'b0;
    run(40'h8000000001, 0, LAST_N, -1);
    check_frame_strobes("t5");
    check("t5_word", dl_word, 40'h8000000001);
    check("t5_cnt", frame_cnt, 1);
    check("t5_valid_cycles", valid_cyc, 1);

    // Enable dropped mid-frame, CLK stopped mid-GAP
    clr();
    run(40'h6B1D29E4C7, 0, 5 * DIV, -1);
    enable = 1'b0;
    run(40'h6B1D29E4C7, 5 * DIV + 1, (NB + 2) * DIV + 3, -1);
    check("t6_word", dl_word, 40'h6B1D29E4C7);
    check("t6_cnt", frame_cnt, 2);
    check("t6_valid_cycles", valid_cyc, 1);
    snap = {DKSTRT, DKBSNC, DKEND, dl_valid, frame_cnt, dl_word, 20'h0};
    for (int i = 0; i < 100; i++) begin
      DKDATA = i[0];
      @(negedge SIM_CLK);
    end
    check("t6_frozen_hi", snap[79:40], {DKSTRT, DKBSNC, DKEND, dl_valid, frame_cnt, dl_word[NB-1:NB-20]});
    check("t6_frozen_lo", snap[39:20], dl_word[19:0]);
    run(40'h6B1D29E4C7, (NB + 2) * DIV + 4, LAST_N, -1);
    check_frame_strobes("t6");
    idle_edges(2 * DIV);
    check("t6_idle_no_strobes", idle_bad, 0);
    check("t6_cnt_final", frame_cnt, 2);
    check("t6_valid_final", dl_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
